// File: rtl/hilo_unit_ctrl.sv
// HI/LO sequencer for the execute stage: drives an external fixed-latency multiplier,
// runs an internal radix-2 restoring divider and owns the architectural HI/LO registers.
module hilo_unit_ctrl #(
  parameter int MUL_LATENCY = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        op_valid,
  input  logic [2:0]  op_code,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        flush,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [63:0] mul_p
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_RUN, DIV_FIX} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q;
  logic        neg_q, qneg_q, rneg_q;
  logic [31:0] dvd_q, dvs_q;
  logic [32:0] rem_q;

  logic        accept, is_mul, is_div, op_signed, div_zero;
  logic        mul_commit, div_commit;
  logic [32:0] trial, rem_nxt;
  logic        q_bit;

  function automatic logic [31:0] mag32(input logic signed [31:0] v, input logic en);
    logic [31:0] u;
    u = v;
    return (en && u[31]) ? (~u + 32'd1) : u;
  endfunction

  function automatic logic [31:0] neg32(input logic [31:0] v, input logic en);
    return en ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] v, input logic en);
    return en ? (~v + 64'd1) : v;
  endfunction

  assign accept     = op_valid && !flush && (state_q == IDLE);
  assign is_mul     = (op_code == OP_MULT) || (op_code == OP_MULTU);
  assign is_div     = (op_code == OP_DIV) || (op_code == OP_DIVU);
  assign op_signed  = (op_code == OP_MULT) || (op_code == OP_DIV);
  assign div_zero   = (op_b == 32'd0);
  assign mul_commit = (state_q == MUL_WAIT) && (cnt_q == 5'(MUL_LATENCY)) && !flush;
  assign div_commit = (state_q == DIV_FIX) && !flush;

  // Restoring divider step: remainder stays below the divisor, so 33 bits suffice.
  assign trial   = {rem_q[31:0], dvd_q[31]};
  assign q_bit   = (trial >= {1'b0, dvs_q});
  assign rem_nxt = q_bit ? (trial - {1'b0, dvs_q}) : trial;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept && is_mul)
          state_d = MUL_WAIT;
        else if (accept && is_div && !div_zero)
          state_d = DIV_RUN;
      end
      MUL_WAIT: if (cnt_q == 5'(MUL_LATENCY)) state_d = IDLE;
      DIV_RUN:  if (cnt_q == 5'd31) state_d = DIV_FIX;
      DIV_FIX:  state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    if (flush && (state_q != IDLE))
      state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy    <= 1'b0;
      cnt_q   <= 5'd0;
      hi      <= 32'd0;
      lo      <= 32'd0;
      mul_a   <= 32'd0;
      mul_b   <= 32'd0;
      neg_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d != IDLE);
      if (accept)
        cnt_q <= 5'd0;
      else if ((state_q == MUL_WAIT) || (state_q == DIV_RUN))
        cnt_q <= cnt_q + 5'd1;

      if (accept) begin
        case (op_code)
          OP_MTHI: hi <= op_a;
          OP_MTLO: lo <= op_a;
          OP_MULT, OP_MULTU: begin
            mul_a <= mag32(op_a, op_signed);
            mul_b <= mag32(op_b, op_signed);
            neg_q <= op_signed && (op_a[31] ^ op_b[31]);
          end
          OP_DIV, OP_DIVU: begin
            if (div_zero) begin
              lo <= 32'hFFFF_FFFF;
              hi <= op_a;
            end else begin
              qneg_q <= op_signed && (op_a[31] ^ op_b[31]);
              rneg_q <= op_signed && op_a[31];
            end
          end
          default: ;
        endcase
      end

      if (mul_commit)
        {hi, lo} <= neg64(mul_p, neg_q);
      if (div_commit) begin
        lo <= neg32(dvd_q, qneg_q);
        hi <= neg32(rem_q[31:0], rneg_q);
      end
    end
  end

  // Divider working registers: dividend shifts out MSB-first while quotient bits shift in.
  always_ff @(posedge clk) begin
    if (accept && is_div) begin
      dvd_q <= mag32(op_a, op_signed);
      dvs_q <= mag32(op_b, op_signed);
      rem_q <= 33'd0;
    end else if (state_q == DIV_RUN) begin
      rem_q <= rem_nxt;
      dvd_q <= {dvd_q[30:0], q_bit};
    end
  end

endmodule

// File: tb/tb_hilo_unit_ctrl.sv
// Self-checking bench for hilo_unit_ctrl: table vectors, corner sequences and
// randomized operations against a plain-arithmetic HI/LO model.
module tb_hilo_unit_ctrl;
  localparam int L = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        op_valid = 1'b0;
  logic [2:0]  op_code = 3'd0;
  logic [31:0] op_a = 32'd0, op_b = 32'd0;
  logic        flush = 1'b0;
  logic        busy;
  logic [31:0] hi, lo, mul_a, mul_b;
  logic [63:0] mul_p;

  logic [63:0] pipe [L];
  int n_chk = 0, n_pass = 0;
  logic [31:0] m_hi = 0, m_lo = 0;

  always #5 clk = ~clk;

  hilo_unit_ctrl #(.MUL_LATENCY(L)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_code(op_code),
    .op_a(op_a), .op_b(op_b), .flush(flush), .busy(busy),
    .hi(hi), .lo(lo), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p)
  );

  // Multiplier core: product of the operands seen L edges earlier.
  initial for (int i = 0; i < L; i++) pipe[i] = 64'd0;
  always @(posedge clk) begin
    pipe[0] <= {32'd0, mul_a} * {32'd0, mul_b};
    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
  end
  assign mul_p = pipe[L-1];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference: architectural result and stall length of one operation.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int cyc);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    cyc = 0;
    case (op)
      3'd1: begin p = sa * sb; {m_hi, m_lo} = p; cyc = L + 1; end
      3'd2: begin p = {32'd0, a} * {32'd0, b}; {m_hi, m_lo} = p; cyc = L + 1; end
      3'd3, 3'd4: begin
        if (b == 0) begin
          m_lo = 32'hFFFF_FFFF; m_hi = a;
        end else begin
          if (op == 3'd4) begin sa = longint'({32'd0, a}); sb = longint'({32'd0, b}); end
          q = sa / sb; r = sa % sb;
          m_lo = q[31:0]; m_hi = r[31:0]; cyc = 33;
        end
      end
      3'd5: m_hi = a;
      3'd6: m_lo = a;
      default: ;
    endcase
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int cyc);
    @(negedge clk);
    op_valid = 1'b1; op_code = op; op_a = a; op_b = b;
    @(negedge clk);
    op_valid = 1'b0;
    cyc = 0;
    while (busy && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  function automatic logic [31:0] pick(input int sel);
    case (sel)
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'd0;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
    int          cyc;
  } vec_t;
  vec_t vecs [9];

  initial begin
    int cyc, ecyc, guard;
    logic stable;
    logic [31:0] sh, sl, a, b;
    logic [2:0] op;

    vecs[0] = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 7};
    vecs[1] = '{3'd1, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 7};
    vecs[2] = '{3'd1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000, 7};
    vecs[3] = '{3'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33};
    vecs[4] = '{3'd4, 32'd100, 32'd7, 32'd2, 32'd14, 33};
    vecs[5] = '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 33};
    vecs[6] = '{3'd3, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 33};
    vecs[7] = '{3'd4, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 0};
    vecs[8] = '{3'd3, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 0};

    repeat (2) @(negedge clk);
    check("reset_hi", hi, 0);
    check("reset_lo", lo, 0);
    check("reset_busy", busy, 0);
    check("reset_mul_a", mul_a, 0);
    check("reset_mul_b", mul_b, 0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, cyc);
      check($sformatf("vec%0d_busy_cycles", i), cyc, vecs[i].cyc);
      check($sformatf("vec%0d_hi", i), hi, vecs[i].hi);
      check($sformatf("vec%0d_lo", i), lo, vecs[i].lo);
    end

    // MTHI then MTLO back-to-back
    @(negedge clk);
    op_valid = 1'b1; op_code = 3'd5; op_a = 32'h1234_5678;
    @(negedge clk);
    check("mthi_hi", hi, 32'h1234_5678);
    check("mthi_busy", busy, 0);
    op_code = 3'd6; op_a = 32'h9ABC_DEF0;
    @(negedge clk);
    op_valid = 1'b0;
    check("mtlo_lo", lo, 32'h9ABC_DEF0);
    check("mtlo_hi_kept", hi, 32'h1234_5678);
    check("mtlo_busy", busy, 0);

    // MULT with a MULTU held while busy
    @(negedge clk);
    op_valid = 1'b1; op_code = 3'd1; op_a = 32'hFFFF_FFFD; op_b = 32'd7;
    @(negedge clk);
    op_code = 3'd2; op_a = 32'd6; op_b = 32'd7;
    stable = 1'b1; guard = 0;
    while (busy && guard < 100) begin
      if (mul_a !== 32'd3 || mul_b !== 32'd7) stable = 1'b0;
      guard++;
      @(negedge clk);
    end
    check("mult_operands_held", stable, 1);
    check("mult_stall_cycles", guard, L + 1);
    check("held_first_hi", hi, 32'hFFFF_FFFF);
    check("held_first_lo", lo, 32'hFFFF_FFEB);
    @(negedge clk);
    check("held_multu_accepted", busy, 1);
    op_valid = 1'b0;
    guard = 0;
    while (busy && guard < 100) begin guard++; @(negedge clk); end
    check("held_multu_lo", lo, 32'd42);
    check("held_multu_hi", hi, 32'd0);

    // flush mid-multiply
    @(negedge clk);
    op_valid = 1'b1; op_code = 3'd1; op_a = 32'd5; op_b = 32'd5;
    @(negedge clk);
    op_valid = 1'b0;
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", busy, 0);
    repeat (L + 3) @(negedge clk);
    check("flush_lo_kept", lo, 32'd42);
    check("flush_hi_kept", hi, 32'd0);

    // flush coinciding with the completion edge
    op_valid = 1'b1; op_code = 3'd2; op_a = 32'd9; op_b = 32'd9;
    @(negedge clk);
    op_valid = 1'b0;
    repeat (L) @(negedge clk);
    check("flush_commit_still_busy", busy, 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_commit_busy", busy, 0);
    check("flush_commit_lo_kept", lo, 32'd42);

    // flush in IDLE blocks MTHI
    op_valid = 1'b1; op_code = 3'd5; op_a = 32'hDEAD_BEEF; flush = 1'b1;
    @(negedge clk);
    op_valid = 1'b0; flush = 1'b0;
    check("flush_idle_hi_kept", hi, 32'd0);

    // asynchronous reset mid-divide
    op_valid = 1'b1; op_code = 3'd4; op_a = 32'd100; op_b = 32'd7;
    @(negedge clk);
    op_valid = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_hi", hi, 0);
    check("arst_lo", lo, 0);
    check("arst_busy", busy, 0);
    check("arst_mul_a", mul_a, 0);
    check("arst_mul_b", mul_b, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(3'd4, 32'd9, 32'd3, cyc);
    check("post_rst_div_lo", lo, 32'd3);
    check("post_rst_div_hi", hi, 32'd0);

    // randomized operations against the model
    m_hi = hi; m_lo = lo;
    for (int k = 0; k < 40; k++) begin
      op = 3'($urandom_range(0, 7));
      a = pick($urandom_range(0, 6));
      b = pick($urandom_range(0, 6));
      model(op, a, b, ecyc);
      run_op(op, a, b, cyc);
      check($sformatf("rand%0d_busy_cycles", k), cyc, ecyc);
      check($sformatf("rand%0d_hi", k), hi, m_hi);
      check($sformatf("rand%0d_lo", k), lo, m_lo);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
